// File: rtl/scalar_seq_ctrl.sv
// Scalar sequencer: runs a small writable instruction memory and drives an external scalar PE.
// Optional step watchdog is compiled in with SCALAR_SEQ_CTRL_WDOG_EN.
package scalar_seq_ctrl_pkg;
   localparam int dwidth_int = 32;
endpackage

module scalar_seq_ctrl
   import scalar_seq_ctrl_pkg::*;
#(
   parameter int IMEM_DEPTH = 16,
   parameter int MAX_STEPS  = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          imem_wr_en,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr,
   input  logic [2:0]                    imem_wr_op,
   input  logic [1:0]                    imem_wr_rd,
   input  logic [1:0]                    imem_wr_rs1,
   input  logic [1:0]                    imem_wr_rs2,
   input  logic [dwidth_int-1:0]         imem_wr_imm,
   output logic [dwidth_int-1:0]         pe_inp1,
   output logic [dwidth_int-1:0]         pe_inp2,
   output logic [dwidth_int-1:0]         pe_imm,
   output logic [2:0]                    pe_op,
   input  logic [dwidth_int-1:0]         pe_out1,
   input  logic                          pe_flag_eq,
   input  logic [1:0]                    reg_sel,
   output logic [dwidth_int-1:0]         reg_data,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);
   // state | meaning
   // IDLE  | waiting for start; instruction memory writable
   // FETCH | imem[pc] latched into the instruction register
   // EXEC  | PE driven from the instruction register; result applied at exit
   // DONE  | one-cycle done pulse, then back to IDLE
   localparam int PCW = $clog2(IMEM_DEPTH);
   localparam logic [PCW-1:0] PC_ONE = 1;
   localparam logic [2:0] OP_LUI  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_BEQ  = 3'b010;
   localparam logic [2:0] OP_NOP  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

   typedef struct packed {
      logic [2:0]            op;
      logic [1:0]            rd;
      logic [1:0]            rs1;
      logic [1:0]            rs2;
      logic [dwidth_int-1:0] imm;
   } instr_t;

   state_t                state, state_nxt;
   logic [PCW-1:0]        pc, pc_nxt;
   instr_t                ir;
   instr_t                imem [IMEM_DEPTH];
   logic [dwidth_int-1:0] regs [4];
   logic                  ir_ld;
   logic                  reg_we;
   logic [dwidth_int-1:0] reg_wdata;
   logic                  start_ok;

   assign start_ok = (state == IDLE) && start;
   assign reg_data = regs[reg_sel];

`ifdef SCALAR_SEQ_CTRL_WDOG_EN
   localparam int WDW = $clog2(MAX_STEPS + 1);
   logic [WDW-1:0] wdog_cnt;
   logic           wdog_trip;
   logic           err_q;

   // Down-counter loaded with MAX_STEPS-1; terminal count on a non-halt EXEC aborts.
   assign wdog_trip = (state == EXEC) && (ir.op != OP_HALT) && (wdog_cnt == '0);
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= '0;
         err_q    <= 1'b0;
      end else if (start_ok) begin
         wdog_cnt <= WDW'(MAX_STEPS - 1);
         err_q    <= 1'b0;
      end else begin
         if (state == EXEC) wdog_cnt <= wdog_cnt - WDW'(1);
         if (wdog_trip) err_q <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_ld     = 1'b0;
      reg_we    = 1'b0;
      reg_wdata = '0;
      pe_op     = OP_NOP;
      pe_inp1   = '0;
      pe_inp2   = '0;
      pe_imm    = '0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               pc_nxt    = '0;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            ir_ld     = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            busy      = 1'b1;
            pe_op     = ir.op;
            pe_inp1   = regs[ir.rs1];
            pe_inp2   = regs[ir.rs2];
            pe_imm    = ir.imm;
            state_nxt = FETCH;
            pc_nxt    = pc + PC_ONE;
            case (ir.op)
               OP_LUI: begin
                  reg_we    = 1'b1;
                  reg_wdata = ir.imm;
               end
               OP_ADDI: begin
                  reg_we    = 1'b1;
                  reg_wdata = pe_out1;
               end
               OP_BEQ: begin
                  if (pe_flag_eq) pc_nxt = ir.imm[PCW-1:0];
               end
               OP_HALT: begin
                  state_nxt = DONE;
                  pc_nxt    = pc;
               end
               default: ;
            endcase
`ifdef SCALAR_SEQ_CTRL_WDOG_EN
            if (wdog_trip) state_nxt = DONE;
`endif
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= '0;
         ir    <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (ir_ld) ir <= imem[pc];
         if (reg_we) regs[ir.rd] <= reg_wdata;
      end
   end

   // Instruction memory has no reset so programs survive rst.
   always_ff @(posedge clk) begin
      if (imem_wr_en && state == IDLE)
         imem[imem_wr_addr] <= {imem_wr_op, imem_wr_rd, imem_wr_rs1, imem_wr_rs2, imem_wr_imm};
   end

endmodule

// File: tb/tb_scalar_seq_ctrl.sv
// Bench for scalar_seq_ctrl: directed programs plus random programs against an
// instruction-level reference model; the PE is an ideal adder/comparator here.
module tb_scalar_seq_ctrl;
   import scalar_seq_ctrl_pkg::*;

   localparam int DEPTH = 16;
   localparam int STEPS = 8;
   localparam int LIM   = 64;
`ifdef SCALAR_SEQ_CTRL_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst, start, imem_wr_en;
   logic [3:0]            imem_wr_addr;
   logic [2:0]            imem_wr_op;
   logic [1:0]            imem_wr_rd, imem_wr_rs1, imem_wr_rs2;
   logic [dwidth_int-1:0] imem_wr_imm;
   logic [dwidth_int-1:0] pe_inp1, pe_inp2, pe_imm, pe_out1;
   logic [2:0]            pe_op;
   logic                  pe_flag_eq;
   logic [1:0]            reg_sel;
   logic [dwidth_int-1:0] reg_data;
   logic                  busy, done, err;

   scalar_seq_ctrl #(.IMEM_DEPTH(DEPTH), .MAX_STEPS(STEPS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_op(imem_wr_op),
      .imem_wr_rd(imem_wr_rd), .imem_wr_rs1(imem_wr_rs1), .imem_wr_rs2(imem_wr_rs2),
      .imem_wr_imm(imem_wr_imm),
      .pe_inp1(pe_inp1), .pe_inp2(pe_inp2), .pe_imm(pe_imm), .pe_op(pe_op),
      .pe_out1(pe_out1), .pe_flag_eq(pe_flag_eq),
      .reg_sel(reg_sel), .reg_data(reg_data),
      .busy(busy), .done(done), .err(err)
   );

   assign pe_out1    = pe_inp1 + pe_imm;
   assign pe_flag_eq = (pe_inp1 == pe_inp2);

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   logic [2:0]            p_op  [DEPTH];
   logic [1:0]            p_rd  [DEPTH];
   logic [1:0]            p_rs1 [DEPTH];
   logic [1:0]            p_rs2 [DEPTH];
   logic [dwidth_int-1:0] p_imm [DEPTH];
   logic [dwidth_int-1:0] mr    [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input int i, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [dwidth_int-1:0] imm);
      p_op[i] = op; p_rd[i] = rd; p_rs1[i] = rs1; p_rs2[i] = rs2; p_imm[i] = imm;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < DEPTH; i++) set_ins(i, 3'b111, 2'd0, 2'd0, 2'd0, '0);
   endtask

   task automatic drive_wr(input int i, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [dwidth_int-1:0] imm);
      imem_wr_en = 1'b1; imem_wr_addr = 4'(i); imem_wr_op = op;
      imem_wr_rd = rd; imem_wr_rs1 = rs1; imem_wr_rs2 = rs2; imem_wr_imm = imm;
   endtask

   task automatic load_prog();
      for (int i = 0; i < DEPTH; i++) begin
         drive_wr(i, p_op[i], p_rd[i], p_rs1[i], p_rs2[i], p_imm[i]);
         tick();
      end
      imem_wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mr[i] = '0;
   endtask

   // Instruction-level model: executes the program on mr[] and reports how it ends.
   task automatic model_run(output int steps, output bit halted, output bit aborted);
      int pc;
      pc = 0; steps = 0; halted = 0; aborted = 0;
      while (!halted && !aborted && steps < LIM) begin
         steps++;
         case (p_op[pc])
            3'b000: begin mr[p_rd[pc]] = p_imm[pc]; pc = (pc + 1) % DEPTH; end
            3'b001: begin mr[p_rd[pc]] = mr[p_rs1[pc]] + p_imm[pc]; pc = (pc + 1) % DEPTH; end
            3'b010: pc = (mr[p_rs1[pc]] == mr[p_rs2[pc]]) ? int'(p_imm[pc][3:0]) : (pc + 1) % DEPTH;
            3'b111: halted = 1;
            default: pc = (pc + 1) % DEPTH;
         endcase
         if (WDOG && !halted && steps == STEPS) aborted = 1;
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         reg_sel = 2'(i);
         #1;
         check($sformatf("%s_r%0d", tag, i), reg_data, mr[i]);
      end
   endtask

   // mode: 0 plain, 1 start+write while busy, 2 slot-0 write with start, 3 no reload
   task automatic run_prog(input string tag, input int mode);
      int  exp_steps, done_at;
      bit  exp_halt, exp_abort;
      model_run(exp_steps, exp_halt, exp_abort);
      if (mode != 3) load_prog();
      if (mode == 2) begin
         drive_wr(0, 3'b111, 2'd0, 2'd0, 2'd0, '0);
         tick();
         drive_wr(0, p_op[0], p_rd[0], p_rs1[0], p_rs2[0], p_imm[0]);
      end
      start = 1'b1;
      tick();
      start = 1'b0; imem_wr_en = 1'b0;
      check({tag, "_err_clr"}, err, 0);
      check({tag, "_busy_run"}, busy, 1);
      done_at = -1;
      for (int c = 1; c <= 2 * LIM; c++) begin
         if (mode == 1 && c == 1) begin
            start = 1'b1;
            drive_wr(1, 3'b000, 2'd2, 2'd0, 2'd0, 32'h0BAD);
         end
         tick();
         start = 1'b0; imem_wr_en = 1'b0;
         if (done) begin
            done_at = c;
            break;
         end
      end
      if (exp_halt || exp_abort) begin
         check({tag, "_done_cyc"}, done_at, 2 * exp_steps);
         check({tag, "_err_done"}, err, exp_abort);
         tick();
         check({tag, "_done_pulse"}, done, 0);
         check({tag, "_busy_after"}, busy, 0);
         check_regs(tag);
      end else begin
         check({tag, "_no_done"}, done_at, -1);
         check({tag, "_still_busy"}, busy, 1);
         do_reset();
         check({tag, "_rst_busy"}, busy, 0);
         check_regs({tag, "_rst"});
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_op = '0;
      imem_wr_rd = '0; imem_wr_rs1 = '0; imem_wr_rs2 = '0; imem_wr_imm = '0; reg_sel = '0;
      tick(); tick();
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_pe_op", pe_op, 3'b011);
      check("rst_pe_inp1", pe_inp1, 0);
      check("rst_pe_imm", pe_imm, 0);
      check_regs("rst");

      clear_prog();
      set_ins(0, 3'b000, 2'd1, 2'd0, 2'd0, 32'd5);
      set_ins(1, 3'b001, 2'd2, 2'd1, 2'd0, 32'd3);
      run_prog("add", 0);
      reg_sel = 2'd2; #1;
      check("add_r2_is_8", reg_data, 32'd8);
      run_prog("add_disturb", 1);

      clear_prog();
      set_ins(0, 3'b000, 2'd0, 2'd0, 2'd0, 32'd0);
      set_ins(1, 3'b000, 2'd3, 2'd0, 2'd0, 32'd3);
      set_ins(2, 3'b001, 2'd0, 2'd0, 2'd0, 32'd1);
      set_ins(3, 3'b010, 2'd0, 2'd0, 2'd3, 32'd5);
      set_ins(4, 3'b010, 2'd0, 2'd0, 2'd0, 32'd2);
      run_prog("loop", 0);

      clear_prog();
      set_ins(0, 3'b000, 2'd1, 2'd0, 2'd0, 32'hFFFF_FFFF);
      set_ins(1, 3'b001, 2'd1, 2'd1, 2'd0, 32'd1);
      run_prog("wrap", 0);
      reg_sel = 2'd1; #1;
      check("wrap_r1_is_0", reg_data, 0);

      clear_prog();
      set_ins(0, 3'b000, 2'd3, 2'd0, 2'd0, 32'h5A);
      run_prog("wr_start", 2);

      do_reset();
      clear_prog();
      set_ins(0, 3'b001, 2'd2, 2'd0, 2'd0, 32'd7);
      load_prog();
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("mid_rst_in_exec", pe_op, 3'b001);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_pe_op", pe_op, 3'b011);
      check("mid_rst_pe_imm", pe_imm, 0);
      check_regs("mid_rst");
      run_prog("imem_kept", 3);

      clear_prog();
      set_ins(0, 3'b010, 2'd0, 2'd0, 2'd0, 32'd0);
      run_prog("spin", 0);
      clear_prog();
      set_ins(0, 3'b000, 2'd1, 2'd0, 2'd0, 32'd9);
      run_prog("after_spin", 0);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < DEPTH; i++) begin
            int r;
            logic [2:0] op;
            r = int'($urandom_range(0, 9));
            if (r < 3)       op = 3'b000;
            else if (r < 6)  op = 3'b001;
            else if (r < 8)  op = 3'b010;
            else if (r == 8) op = 3'b111;
            else             op = 3'(3 + $urandom_range(0, 3));
            set_ins(i, op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    (op == 3'b010) ? 32'($urandom_range(0, 15)) :
                    ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4)));
         end
         run_prog($sformatf("rnd%0d", n), 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/scalar_seq_ctrl.md
SCALAR_SEQ_CTRL -- requirements
Module: scalar_seq_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, instruction slots (power of two; PC width = log2(IMEM_DEPTH)).
REQ-002 SHALL have parameter MAX_STEPS, default 1024, watchdog instruction limit (used only under REQ-029).
REQ-003 SHALL take the data width dwidth_int from the shared interface header; it SHALL NOT be a parameter.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins execution at PC 0
- imem_wr_en  in  1  write one instruction slot
- imem_wr_addr  in  log2(IMEM_DEPTH)  slot index
- imem_wr_op  in  3  opcode
- imem_wr_rd  in  2  destination register index
- imem_wr_rs1  in  2  source-1 register index
- imem_wr_rs2  in  2  source-2 register index
- imem_wr_imm  in  dwidth_int  immediate; low PC bits are the branch target
- pe_inp1  out  dwidth_int  R[rs1] to the scalar PE
- pe_inp2  out  dwidth_int  R[rs2] to the scalar PE
- pe_imm  out  dwidth_int  immediate to the scalar PE
- pe_op  out  3  opcode to the scalar PE
- pe_out1  in  dwidth_int  PE result (combinational, same cycle)
- pe_flag_eq  in  1  PE equality flag (combinational, same cycle)
- reg_sel  in  2  debug read-back select
- reg_data  out  dwidth_int  R[reg_sel] (combinational)
- busy  out  1  program executing
- done  out  1  one-cycle pulse on halt
- err  out  1  sticky watchdog abort flag

Function
REQ-006 SHALL use opcodes lui=000, addi=001, beq=010 and halt=111; all other opcodes SHALL be NOPs.
REQ-007 SHALL hold four dwidth_int registers R0..R3 and an IMEM_DEPTH-entry instruction memory.
REQ-008 SHALL use FSM states IDLE, FETCH, EXEC and DONE.
REQ-009 IDLE: start=1 SHALL set PC=0 and enter FETCH; busy SHALL be 1 in FETCH and EXEC only.
REQ-010 FETCH SHALL latch imem[PC] into the instruction register and then enter EXEC.
REQ-011 EXEC SHALL drive pe_op, pe_inp1, pe_inp2 and pe_imm from the instruction register and sample pe_out1/pe_flag_eq at the clock edge that ends EXEC.
REQ-012 Outside EXEC, pe_op SHALL be 3'b011 (a NOP) and pe_inp1, pe_inp2 and pe_imm SHALL be 0.
REQ-013 lui SHALL set R[rd]=imm locally (the PE result is ignored), then PC=PC+1.
REQ-014 addi SHALL set R[rd]=pe_out1, truncated to dwidth_int (wraps modulo 2^dwidth_int), then PC=PC+1.
REQ-015 beq with pe_flag_eq=1 SHALL set PC=imm[log2(IMEM_DEPTH)-1:0]; otherwise PC=PC+1; it SHALL write no register.
REQ-016 A NOP SHALL set PC=PC+1 and change no register.
REQ-017 After a non-halt instruction, EXEC SHALL return to FETCH; every instruction takes exactly 2 cycles.
REQ-018 PC increment SHALL wrap from IMEM_DEPTH-1 to 0.
REQ-019 halt in EXEC SHALL enter DONE; DONE SHALL assert done for one cycle and then enter IDLE.
REQ-020 start while busy=1 or while in DONE SHALL be ignored.
REQ-021 imem_wr_en SHALL write only when the FSM is in IDLE; writes in any other state SHALL be dropped.
REQ-022 imem_wr_en and start in the same IDLE cycle: the write SHALL land first, and the first FETCH SHALL see the written slot.
REQ-023 Registers SHALL retain their values across programs; only reset clears them.
REQ-024 A write with rd=rs1 SHALL use the pre-write value of rs1 as the source.

Reset
REQ-025 rst SHALL force state=IDLE, PC=0, instruction register=0, R0..R3=0, busy=0, done=0 and err=0.
REQ-026 rst mid-program SHALL abort execution on the next edge with no further register writes.
REQ-027 rst SHALL NOT clear the instruction memory, whose contents SHALL survive reset.

Configuration
REQ-028 Macro SCALAR_SEQ_CTRL_WDOG_EN SHALL compile the watchdog in or out.
REQ-029 With the macro defined:
- a step counter SHALL clear on start and increment per EXEC
- reaching MAX_STEPS without a halt SHALL set err=1, pulse done and return to IDLE
- err SHALL clear on the next accepted start or on rst
REQ-030 Without the macro, there SHALL be no counter, err SHALL be tied to 0, and a non-halting program SHALL run until rst.

Verification
REQ-031 Program lui R1,5; addi R2,R1,3; halt -> R2=8, done pulses exactly 6 cycles after start, busy=0 after.
REQ-032 Program lui R0,0; lui R3,3; addi R0,R0,1; beq R0,R3,->5; beq R0,R0,->2; halt -> R0=3, halt reached, no err.
REQ-033 With dwidth_int=32, program lui R1,0xFFFFFFFF; addi R1,R1,1; halt -> R1=0.
REQ-034 Second start pulse during execution, plus an imem write while busy -> both ignored, result unchanged from the single-start run.
REQ-035 rst asserted in the EXEC of an addi -> the target register stays 0; outputs match reset values on the next cycle.
REQ-036 With SCALAR_SEQ_CTRL_WDOG_EN and MAX_STEPS=8, program beq R0,R0,->0 -> err=1 and done pulses after 8 EXECs; a following start clears err.
